// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer
// Two-entry skid buffer between the ALU (EX) and the memory stage (MEM).
// Each accepted entry carries the ALU result together with its instruction
// context. A valid/ready handshake runs on both sides. exReady depends only
// on registered state, so MEM back-pressure never reaches EX combinationally.
// Accepting an entry with a non-zero exception code locks intake until
// flush or reset. Entries already buffered, and the faulting entry itself,
// still drain normally.
//
// Ports:
//   aclk, reset            clock, synchronous active-high reset
//   flush                  kills buffered entries and the exception lock
//   exValid / exReady      EX-side handshake
//   aluOut .. pc           entry payload from EX
//   memValid / memReady    MEM-side handshake
//   memAluOut .. memPc     head entry payload (reads 0 while empty)
//   excPending             faulting entry accepted, intake locked
//   stallCycles            cycles where EX offered an entry but was refused
module ex_mem_buffer #(
    parameter int INSTR_SIZE = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  exValid,
    output logic                  exReady,
    input  logic [INSTR_SIZE-1:0] aluOut,
    input  logic                  zero,
    input  logic [INSTR_SIZE-1:0] exceptionCode,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR-1:0]   rd,
    input  logic [INSTR_SIZE-1:0] storeData,
    input  logic [INSTR_SIZE-1:0] pc,
    output logic                  memValid,
    input  logic                  memReady,
    output logic [INSTR_SIZE-1:0] memAluOut,
    output logic                  memZero,
    output logic [INSTR_SIZE-1:0] memException,
    output logic [6:0]            memOpcode,
    output logic [REG_ADDR-1:0]   memRd,
    output logic [INSTR_SIZE-1:0] memStoreData,
    output logic [INSTR_SIZE-1:0] memPc,
    output logic                  excPending,
    output logic [31:0]           stallCycles
);

    // Entry storage. The payload is not reset; it is masked at the outputs
    // while the buffer is empty.
    logic [INSTR_SIZE-1:0] aluq   [2];
    logic                  zeroq  [2];
    logic [INSTR_SIZE-1:0] excq   [2];
    logic [6:0]            opq    [2];
    logic [REG_ADDR-1:0]   rdq    [2];
    logic [INSTR_SIZE-1:0] storeq [2];
    logic [INSTR_SIZE-1:0] pcq    [2];

    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       enq;
    logic       deq;
    logic       fault_in;

    assign exReady  = (count != 2'd2) && !excPending;
    assign memValid = (count != 2'd0);

    assign enq      = exValid && exReady;
    assign deq      = memValid && memReady;
    assign fault_in = (exceptionCode != '0);

    // Control state: pointers, occupancy and exception lock.
    always_ff @(posedge aclk) begin
        if (reset) begin
            head       <= 1'b0;
            tail       <= 1'b0;
            count      <= 2'd0;
            excPending <= 1'b0;
        end else if (flush) begin
            head       <= 1'b0;
            tail       <= 1'b0;
            count      <= 2'd0;
            excPending <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 2'd1;
            end else if (deq && !enq) begin
                count <= count - 2'd1;
            end
            // The lock takes effect at the same edge the faulting entry lands.
            if (enq && fault_in) begin
                excPending <= 1'b1;
            end
        end
    end

    // Refused-offer counter. It survives flush and wraps naturally.
    always_ff @(posedge aclk) begin
        if (reset) begin
            stallCycles <= 32'd0;
        end else if (exValid && !exReady && !flush) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end

    // Payload write at the tail. Reset and flush suppress the write so a
    // killed entry can never be mistaken for a live one.
    always_ff @(posedge aclk) begin
        if (enq && !flush && !reset) begin
            aluq[tail]   <= aluOut;
            zeroq[tail]  <= zero;
            excq[tail]   <= exceptionCode;
            opq[tail]    <= opcode;
            rdq[tail]    <= rd;
            storeq[tail] <= storeData;
            pcq[tail]    <= pc;
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        memAluOut    = '0;
        memZero      = 1'b0;
        memException = '0;
        memOpcode    = '0;
        memRd        = '0;
        memStoreData = '0;
        memPc        = '0;
        if (memValid) begin
            memAluOut    = aluq[head];
            memZero      = zeroq[head];
            memException = excq[head];
            memOpcode    = opq[head];
            memRd        = rdq[head];
            memStoreData = storeq[head];
            memPc        = pcq[head];
        end
    end

endmodule

// File: tb/tb_ex_mem_buffer.sv
module tb_ex_mem_buffer;

    localparam int W = 32;
    localparam int R = 5;
    localparam int EW = W + 1 + W + 7 + R + W + W;

    logic          aclk = 1'b0;
    logic          reset;
    logic          flush;
    logic          exValid;
    logic          exReady;
    logic [W-1:0]  aluOut;
    logic          zero;
    logic [W-1:0]  exceptionCode;
    logic [6:0]    opcode;
    logic [R-1:0]  rd;
    logic [W-1:0]  storeData;
    logic [W-1:0]  pc;
    logic          memValid;
    logic          memReady;
    logic [W-1:0]  memAluOut;
    logic          memZero;
    logic [W-1:0]  memException;
    logic [6:0]    memOpcode;
    logic [R-1:0]  memRd;
    logic [W-1:0]  memStoreData;
    logic [W-1:0]  memPc;
    logic          excPending;
    logic [31:0]   stallCycles;

    int vectors = 0;
    int miscompares = 0;

    logic [EW-1:0] expq[$];

    ex_mem_buffer #(.INSTR_SIZE(W), .REG_ADDR(R)) dut (
        .aclk(aclk), .reset(reset), .flush(flush),
        .exValid(exValid), .exReady(exReady),
        .aluOut(aluOut), .zero(zero), .exceptionCode(exceptionCode),
        .opcode(opcode), .rd(rd), .storeData(storeData), .pc(pc),
        .memValid(memValid), .memReady(memReady),
        .memAluOut(memAluOut), .memZero(memZero), .memException(memException),
        .memOpcode(memOpcode), .memRd(memRd), .memStoreData(memStoreData),
        .memPc(memPc), .excPending(excPending), .stallCycles(stallCycles)
    );

    always #5 aclk = ~aclk;

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish (actual=timeout, required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Drive one offer from EX; push the expected entry if it should be accepted.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] exc,
                         input logic [R-1:0] rdv, input logic [W-1:0] pcv,
                         input bit accept);
        logic [6:0]   op;
        logic [W-1:0] sd;
        logic         z;
        op = a[6:0] ^ 7'h33;
        sd = ~a;
        z  = (a == '0);
        exValid       = 1'b1;
        aluOut        = a;
        zero          = z;
        exceptionCode = exc;
        opcode        = op;
        rd            = rdv;
        storeData     = sd;
        pc            = pcv;
        if (accept) expq.push_back({a, z, exc, op, rdv, sd, pcv});
    endtask

    task automatic idle();
        exValid       = 1'b0;
        aluOut        = 32'hDEAD_BEEF;
        zero          = 1'b1;
        exceptionCode = 32'h7;
        opcode        = 7'h7F;
        rd            = 5'h1F;
        storeData     = 32'hFFFF_FFFF;
        pc            = 32'hFFFF_FFF0;
    endtask

    // Monitor: every MEM handshake consumes the oldest expected entry.
    always @(negedge aclk) begin
        if (!reset && !flush && memValid && memReady) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_entry: actual aluOut=%0h required=no entry", memAluOut);
            end else begin
                chk("mem_entry",
                    {memAluOut, memZero, memException, memOpcode, memRd, memStoreData, memPc},
                    expq.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        memReady = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk("reset_memValid", memValid, 0);
        chk("reset_exReady", exReady, 1);
        chk("reset_excPending", excPending, 0);
        chk("reset_stall", stallCycles, 0);
        chk("reset_memAluOut", memAluOut, 0);

        // Pass-through
        memReady = 1'b1;
        drive(30, 0, 5, 32'h100, 1);
        tick();
        idle();
        chk("pass_memValid", memValid, 1);
        chk("pass_memRd", memRd, 5);
        tick();
        chk("pass_drained", memValid, 0);

        // Full / back-pressure
        memReady = 1'b0;
        drive(10, 0, 1, 32'h200, 1);
        tick();
        drive(20, 0, 2, 32'h204, 1);
        tick();
        chk("full_exReady", exReady, 0);
        drive(99, 0, 3, 32'h208, 0);
        tick();
        tick();
        tick();
        idle();
        chk("full_stall", stallCycles, 3);
        memReady = 1'b1;
        tick();
        chk("full_exReady_back", exReady, 1);
        tick();
        chk("full_drained", memValid, 0);

        // Simultaneous enqueue/dequeue at count=1
        memReady = 1'b0;
        drive(7, 0, 7, 32'h300, 1);
        tick();
        idle();
        memReady = 1'b1;
        drive(9, 0, 9, 32'h304, 1);
        tick();
        idle();
        chk("simul_memValid", memValid, 1);
        chk("simul_head", memAluOut, 9);
        tick();
        chk("simul_drained", memValid, 0);

        // Exception lock
        memReady = 1'b0;
        drive(1, 0, 1, 32'h400, 1);
        tick();
        drive(2, 1, 2, 32'h404, 1);
        tick();
        chk("exc_pending", excPending, 1);
        chk("exc_exReady", exReady, 0);
        drive(3, 0, 3, 32'h408, 0);
        tick();
        memReady = 1'b1;
        tick();
        tick();
        idle();
        chk("exc_drained", memValid, 0);
        chk("exc_still_locked", exReady, 0);
        chk("exc_stall", stallCycles, 6);

        // Flush
        flush = 1'b1;
        memReady = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_unlock", excPending, 0);
        drive(40, 0, 4, 32'h500, 1);
        tick();
        drive(41, 5, 4, 32'h504, 1);
        tick();
        chk("flush_pre_pending", excPending, 1);
        drive(55, 0, 5, 32'h508, 0);
        flush = 1'b1;
        memReady = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        expq.delete();
        chk("flush_memValid", memValid, 0);
        chk("flush_excPending", excPending, 0);
        chk("flush_exReady", exReady, 1);
        chk("flush_stall_kept", stallCycles, 6);
        tick();
        chk("flush_no55", memValid, 0);

        // Reset mid-operation
        memReady = 1'b0;
        drive(60, 0, 6, 32'h600, 1);
        tick();
        idle();
        chk("rst_pre_valid", memValid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expq.delete();
        chk("rst_memValid", memValid, 0);
        chk("rst_memAluOut", memAluOut, 0);
        chk("rst_stall", stallCycles, 0);
        chk("rst_exReady", exReady, 1);

        tick();
        tick();
        chk("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_buffer.md
Name: ex_mem_buffer

Overview:
Two-entry skid buffer between the ALU (EX) and the memory stage (MEM). It captures each ALU result along with its instruction context: aluOut, zero, exceptionCode, opcode, rd, store data and pc. It decouples MEM back-pressure from EX through a valid/ready handshake on both sides. It also enforces precise exceptions: once a faulting entry is accepted, intake stops until the pipeline is flushed.

Parameters:
INSTR_SIZE, 32, data/address width of aluOut, storeData, pc, exceptionCode
REG_ADDR, 5, width of destination register index

Ports:
aclk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all buffered entries and exception lock
exValid  input  1  EX presents a valid ALU result this cycle
exReady  output  1  buffer can accept an entry this cycle
aluOut  input  INSTR_SIZE  ALU result
zero  input  1  ALU zero flag
exceptionCode  input  INSTR_SIZE  ALU exception code, 0 = none
opcode  input  7  instruction opcode
rd  input  REG_ADDR  destination register
storeData  input  INSTR_SIZE  rs2 value for stores
pc  input  INSTR_SIZE  instruction pc
memValid  output  1  head entry valid
memReady  input  1  MEM accepts head entry
memAluOut  output  INSTR_SIZE  head aluOut
memZero  output  1  head zero
memException  output  INSTR_SIZE  head exceptionCode
memOpcode  output  7  head opcode
memRd  output  REG_ADDR  head rd
memStoreData  output  INSTR_SIZE  head storeData
memPc  output  INSTR_SIZE  head pc
excPending  output  1  faulting entry accepted, intake locked
stallCycles  output  32  count of cycles with exValid=1 and exReady=0

Behaviour:
- Storage: 2 entries, head pointer (1 bit), tail pointer (1 bit), count (0..2); pointers wrap modulo 2.
- Reset (reset=1 at edge): count=0, head=tail=0, excPending=0, stallCycles=0. All mem* data outputs read 0 while empty; memValid=0; exReady=1 the cycle after reset.
- exReady = (count != 2) && !excPending; purely from registered state, no combinational path from memReady.
- Enqueue when exValid && exReady: write entry at tail, tail++.
- Dequeue when memValid && memReady: head++.
- Count update:
  - enqueue only: count+1
  - dequeue only: count-1
  - both in the same cycle: count unchanged; legal at count=1, and at count=0 it cannot occur because memValid=0.
- memValid = (count != 0). mem* outputs are driven from the head entry; they are held stable while memValid && !memReady.
- Latency: an entry accepted at edge N is visible on mem* after edge N, i.e. 1 cycle, when the buffer was empty.
- Exception lock:
  - On enqueue of an entry with exceptionCode != 0, excPending goes to 1 at the same edge.
  - Entries already buffered ahead of it still drain normally. The faulting entry itself is presented and dequeued normally.
  - exReady stays 0 until flush or reset.
- Flush: count=0, head=tail=0, excPending=0 at the edge.
  - Flush overrides a simultaneous enqueue and dequeue: nothing is accepted; the dequeue handshake is ignored.
  - stallCycles is not cleared.
- stallCycles increments by 1 on each edge with exValid=1 && exReady=0 && !flush && !reset; it wraps from 0xFFFFFFFF to 0.
- Priority: reset > flush > enqueue/dequeue.
- exValid=0 with arbitrary data inputs has no effect on state.

Test Plan:
- Pass-through: memReady=1; enqueue aluOut=30, rd=5, pc=0x100 -> next cycle memValid=1, memAluOut=30, memRd=5, memPc=0x100; cycle after, memValid=0.
- Full/back-pressure: memReady=0; enqueue 10 then 20 -> exReady=0, count 2. Hold exValid=1 for 3 more cycles -> stallCycles=3. Set memReady=1 -> outputs 10 then 20 in order; exReady returns to 1 after the first dequeue.
- Simultaneous enq/deq at count=1: with one entry (aluOut=7) present and memReady=1, enqueue 9 -> 7 dequeued, 9 at head; count stays 1; memValid never drops.
- Exception lock: enqueue aluOut=1, then aluOut=2 with exceptionCode=1 -> excPending=1, exReady=0. Both entries drain in order, memException=1 on the second. A further exValid is not accepted.
- Flush: with 2 entries buffered and excPending=1, assert flush together with exValid=1 (aluOut=55) -> next cycle memValid=0, excPending=0, exReady=1, and 55 is not stored.
- Reset mid-operation: with 1 entry buffered and stallCycles=4, assert reset -> memValid=0, memAluOut=0, stallCycles=0, exReady=1 afterwards.
